dly_flush: RTL and testbench
============================

Name: dly_flush

Overview:
- Upstream companion of a fixed-depth register delay line that holds back its last LEN items until newer items push them out.
- Forwards a valid/ready (dti) stream through one registered stage.
- After forwarding a transaction's last item (eot flag set), injects exactly LEN tagged filler items so the downstream delay line fully drains.
- Downstream discards filler items using the tag bit.

Parameters:
- LEN, 5, number of filler items injected per flush; legal range 1..255.
- W_DIN, 16, input data width. Bit W_DIN-1 is the eot flag and the remaining bits are payload.
- FILL, 0, W_DIN-bit value placed in the data field of filler items. Its eot bit is forced to 0.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset: synchronous, active-high.
- din_data, input, W_DIN, dti.consumer data; bit W_DIN-1 is eot.
- din_valid, input, 1, dti.consumer valid.
- din_ready, output, 1, dti.consumer ready; combinational.
- dout_data, output, W_DIN+1, dti.producer data; bit W_DIN is the filler tag, bits W_DIN-1:0 are the data.
- dout_valid, output, 1, dti.producer valid; registered.
- dout_ready, input, 1, dti.producer ready.

Behaviour:
- Reset, synchronous while rst=1:
  - dout_valid=0, dout_data=0, state=PASS, fill_cnt=0.
  - din_ready is forced 0 while rst=1.
- Output register:
  - free = !dout_valid || dout_ready.
  - A transfer occurs when dout_valid && dout_ready.
  - dout_data and dout_valid never change while dout_valid=1 && dout_ready=0.
- State PASS:
  - din_ready = free.
  - On an accept (din_valid && din_ready): dout_data <= {1'b0, din_data}, dout_valid <= 1.
  - If the accepted item has eot=1: state <= FLUSH, fill_cnt <= 0.
  - If free and no accept: dout_valid <= 0.
- State FLUSH:
  - din_ready = 0.
  - Each cycle free=1: dout_data <= {1'b1, FILL with bit W_DIN-1 cleared}, dout_valid <= 1, fill_cnt <= fill_cnt+1.
  - When fill_cnt==LEN-1 is loaded, state <= PASS in the same edge.
- Latency and throughput:
  - Latency din accept -> dout_valid is 1 cycle.
  - Full throughput of 1 item/cycle when dout_ready=1, in both pass and flush.
  - The first non-filler item after a flush can be accepted in the cycle after the last filler is loaded.
- Backpressure: holding dout_ready=0 stalls fill_cnt. No filler is skipped or duplicated.
- eot item followed immediately by another valid din: the second item waits (din_ready=0) for LEN filler transfers.
- Back-to-back single-item transactions, each with eot=1: every item is followed by exactly LEN fillers.
- Reset mid-flush: the flush is abandoned, remaining fillers are not emitted, and the block returns to PASS.
- fill_cnt width is 8 bits.

Optional Feature:
- Macro: DLY_FLUSH_REQ_EN.
- Defined:
  - Adds input port flush_req (1 bit, level-sampled).
  - In PASS, flush_req=1 sends the block to FLUSH, fill_cnt <= 0, on that edge.
  - If a din accept happens on the same edge, the item is loaded first and the flush follows, identical to the eot case.
  - flush_req is ignored in FLUSH.
- Undefined: no port; flushes are triggered only by eot.

Test Plan (LEN=5, W_DIN=16, FILL=16'h0000):
- Reset then idle -> dout_valid=0, dout_data=0, din_ready=0 while rst=1 and din_ready=1 after.
- Send 16'h0011, 16'h0022, 16'h8033 with dout_ready=1 -> dout sequence 17'h00011, 17'h00022, 17'h08033, then 5x 17'h10000 on consecutive cycles; din_ready=0 for 5 cycles.
- As above, but hold 16'h0044 valid right after eot -> 16'h0044 emerges as 17'h00044 exactly after the 5th filler, with no gap.
- Random dout_ready stalls (~50%) during a flush -> exactly 5 fillers; dout_data stable during stalls.
- Assert rst after 2 fillers -> dout_valid=0 the next cycle; a new item 16'h0055 passes with no remaining fillers.
- DLY_FLUSH_REQ_EN: pulse flush_req with no din -> 5 fillers. Pulse it together with accept of 16'h0066 -> 17'h00066 then 5 fillers.

Source files
------------

// File: rtl/dly_flush_if.sv
// Valid/ready (dti) stream bundle shared by the dly_flush input and output sides.
interface dly_flush_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dly_flush.sv
// Forwards a dti stream through one register stage and, after each eot item, injects LEN
// tagged filler items so a downstream delay line drains. Optional DLY_FLUSH_REQ_EN adds flush_req.
module dly_flush #(
  parameter int               LEN   = 5,
  parameter int               W_DIN = 16,
  parameter logic [W_DIN-1:0] FILL  = {W_DIN{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DLY_FLUSH_REQ_EN
  input  logic        flush_req,
`endif
  dly_flush_if.slave  din,
  dly_flush_if.master dout
);

  typedef enum logic [0:0] {
    ST_PASS  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [7:0]     LAST_CNT  = 8'(LEN - 1);
  // Filler carries the tag bit set and never carries an eot flag.
  localparam logic [W_DIN:0] FILL_ITEM = {1'b1, 1'b0, FILL[W_DIN-2:0]};

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       fill_cnt_r;
  logic [7:0]       fill_cnt_s;
  logic [W_DIN:0]   dout_data_r;
  logic [W_DIN:0]   dout_data_s;
  logic             dout_valid_r;
  logic             dout_valid_s;
  logic             free_s;
  logic             accept_s;
  logic             din_ready_s;
  logic             flush_req_s;

`ifdef DLY_FLUSH_REQ_EN
  assign flush_req_s = flush_req;
`else
  assign flush_req_s = 1'b0;
`endif

  assign free_s     = !dout_valid_r || dout.ready;
  assign din.ready  = din_ready_s;
  assign dout.data  = dout_data_r;
  assign dout.valid = dout_valid_r;

  // Next-state, output-stage load and input handshake decode.
  always_comb begin
    state_s      = state_r;
    fill_cnt_s   = fill_cnt_r;
    dout_data_s  = dout_data_r;
    dout_valid_s = dout_valid_r;
    din_ready_s  = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      ST_PASS: begin
        din_ready_s = free_s && !rst;
        accept_s    = din.valid && din_ready_s;
        if (accept_s) begin
          dout_data_s  = {1'b0, din.data};
          dout_valid_s = 1'b1;
        end else if (free_s) begin
          dout_valid_s = 1'b0;
        end else begin
          dout_valid_s = dout_valid_r;
        end
        // The accepted item is loaded first; a flush request then behaves like an eot.
        if ((accept_s && din.data[W_DIN-1]) || flush_req_s) begin
          state_s    = ST_FLUSH;
          fill_cnt_s = 8'd0;
        end else begin
          state_s    = ST_PASS;
        end
      end
      ST_FLUSH: begin
        if (free_s) begin
          dout_data_s  = FILL_ITEM;
          dout_valid_s = 1'b1;
          fill_cnt_s   = fill_cnt_r + 8'd1;
          if (fill_cnt_r == LAST_CNT) begin
            state_s = ST_PASS;
          end else begin
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s      = ST_PASS;
        fill_cnt_s   = 8'd0;
        dout_valid_s = 1'b0;
      end
    endcase
  end

  // State, fill counter and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_PASS;
      fill_cnt_r   <= 8'd0;
      dout_data_r  <= {(W_DIN+1){1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      fill_cnt_r   <= fill_cnt_s;
      dout_data_r  <= dout_data_s;
      dout_valid_r <= dout_valid_s;
    end
  end

endmodule

// File: tb/tb_dly_flush.sv
// Directed self-checking bench for dly_flush (LEN=5, W_DIN=16, FILL=0); inputs change and
// outputs are sampled on the falling clock edge.
module tb_dly_flush;

  localparam logic [16:0] FILLER = 17'h10000;

  logic clk = 1'b0;
  logic rst;
  logic flush_req;
  int   checks = 0;
  int   errors = 0;

  dly_flush_if #(.W(16)) din_if ();
  dly_flush_if #(.W(17)) dout_if ();

  always #5 clk = ~clk;

  dly_flush #(.LEN(5), .W_DIN(16), .FILL(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DLY_FLUSH_REQ_EN
    .flush_req (flush_req),
`endif
    .din       (din_if),
    .dout      (dout_if)
  );

  task automatic test_reset();
    rst = 1'b1; flush_req = 1'b0;
    din_if.data = 16'h0000; din_if.valid = 1'b0; dout_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0 || dout_if.data !== 17'h00000 || din_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h din_ready=%b, want 0/00000/0",
               dout_if.valid, dout_if.data, din_if.ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (din_if.ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", din_if.ready);
    end
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid: got %b want 0", dout_if.valid);
    end
  endtask

  task automatic test_pass_flush();
    logic [15:0] vec [0:2];
    vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h8033;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_if.data = vec[i]; din_if.valid = 1'b1; #1;
      checks++;
      if (din_if.ready !== 1'b1) begin
        errors++; $display("FAIL pass_ready[%0d]: got %b want 1", i, din_if.ready);
      end
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== {1'b0, vec[i]}) begin
        errors++;
        $display("FAIL pass_item[%0d]: valid=%b data=%h want 1/%h", i, dout_if.valid,
                 dout_if.data, {1'b0, vec[i]});
      end
    end
    din_if.valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (din_if.ready !== 1'b0) begin
        errors++; $display("FAIL flush_ready[%0d]: got %b want 0", k, din_if.ready);
      end
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== FILLER) begin
        errors++;
        $display("FAIL flush_filler[%0d]: valid=%b data=%h want 1/%h", k, dout_if.valid,
                 dout_if.data, FILLER);
      end
    end
    #1;
    checks++;
    if (din_if.ready !== 1'b1) begin
      errors++; $display("FAIL flush_end_ready: got %b want 1", din_if.ready);
    end
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0) begin
      errors++; $display("FAIL flush_end_valid: got %b want 0", dout_if.valid);
    end
  endtask

  task automatic test_eot_hold();
    logic [15:0] vec [0:2];
    vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h8033;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_if.data = vec[i]; din_if.valid = 1'b1;
      @(negedge clk);
      checks++;
      if (dout_if.data !== {1'b0, vec[i]}) begin
        errors++; $display("FAIL hold_item[%0d]: got %h want %h", i, dout_if.data, {1'b0, vec[i]});
      end
    end
    din_if.data = 16'h0044;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (din_if.ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b want 0", k, din_if.ready);
      end
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== FILLER) begin
        errors++;
        $display("FAIL hold_filler[%0d]: valid=%b data=%h want 1/%h", k, dout_if.valid,
                 dout_if.data, FILLER);
      end
    end
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 17'h00044) begin
      errors++;
      $display("FAIL hold_next_item: valid=%b data=%h want 1/00044", dout_if.valid, dout_if.data);
    end
    din_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0) begin
      errors++; $display("FAIL hold_idle: got %b want 0", dout_if.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [0:1];
    vec[0] = 16'h8077; vec[1] = 16'h8088;
    dout_if.ready = 1'b1;
    din_if.valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      din_if.data = vec[j]; #1;
      checks++;
      if (din_if.ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", j, din_if.ready);
      end
      @(negedge clk);
      checks++;
      if (dout_if.data !== {1'b0, vec[j]}) begin
        errors++; $display("FAIL b2b_item[%0d]: got %h want %h", j, dout_if.data, {1'b0, vec[j]});
      end
      if (j == 1) din_if.valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checks++;
        if (dout_if.valid !== 1'b1 || dout_if.data !== FILLER) begin
          errors++;
          $display("FAIL b2b_filler[%0d][%0d]: valid=%b data=%h want 1/%h", j, k,
                   dout_if.valid, dout_if.data, FILLER);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got %b want 0", dout_if.valid);
    end
  endtask

  task automatic test_stall();
    int          fills = 0;
    int          items = 0;
    logic [16:0] pd;
    logic        pv;
    logic        rdy;
    dout_if.ready = 1'b1;
    din_if.data = 16'h8099; din_if.valid = 1'b1;
    @(negedge clk);
    din_if.valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rdy = (c >= 28) ? 1'b1 : 1'($urandom_range(0, 1));
      dout_if.ready = rdy;
      pv = dout_if.valid; pd = dout_if.data;
      @(negedge clk);
      if (pv && rdy) begin
        if (pd[16]) begin
          fills++;
          checks++;
          if (pd !== FILLER) begin
            errors++; $display("FAIL stall_filler_data: got %h want %h", pd, FILLER);
          end
        end else begin
          items++;
        end
      end
      if (pv && !rdy) begin
        checks++;
        if (dout_if.valid !== 1'b1 || dout_if.data !== pd) begin
          errors++;
          $display("FAIL stall_hold[%0d]: valid=%b data=%h want 1/%h", c, dout_if.valid,
                   dout_if.data, pd);
        end
      end
    end
    checks++;
    if (fills != 5 || items != 1) begin
      errors++; $display("FAIL stall_counts: fillers=%0d items=%0d want 5/1", fills, items);
    end
    checks++;
    if (dout_if.valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle: got %b want 0", dout_if.valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    dout_if.ready = 1'b1;
    din_if.data = 16'h80AA; din_if.valid = 1'b1;
    @(negedge clk);
    din_if.valid = 1'b0;
    checks++;
    if (dout_if.data !== 17'h080AA) begin
      errors++; $display("FAIL rmf_item: got %h want 080aa", dout_if.data);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== FILLER) begin
        errors++; $display("FAIL rmf_filler[%0d]: got %b/%h", k, dout_if.valid, dout_if.data);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dout_if.valid !== 1'b0 || din_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL rmf_reset: valid=%b din_ready=%b want 0/0", dout_if.valid, din_if.ready);
    end
    rst = 1'b0;
    din_if.data = 16'h0055; din_if.valid = 1'b1; #1;
    checks++;
    if (din_if.ready !== 1'b1) begin
      errors++; $display("FAIL rmf_ready: got %b want 1", din_if.ready);
    end
    @(negedge clk);
    din_if.valid = 1'b0;
    checks++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 17'h00055) begin
      errors++; $display("FAIL rmf_new_item: got %b/%h want 1/00055", dout_if.valid, dout_if.data);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b0) begin
        errors++; $display("FAIL rmf_no_filler[%0d]: valid=%b data=%h", k, dout_if.valid, dout_if.data);
      end
    end
  endtask

`ifdef DLY_FLUSH_REQ_EN
  task automatic test_flush_req();
    dout_if.ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      flush_req = 1'b1;
      din_if.data = 16'h0066; din_if.valid = (j == 1);
      @(negedge clk);
      flush_req = 1'b0; din_if.valid = 1'b0;
      checks++;
      if (j == 0 && dout_if.valid !== 1'b0) begin
        errors++; $display("FAIL freq_idle_pulse: got %b want 0", dout_if.valid);
      end else if (j == 1 && (dout_if.valid !== 1'b1 || dout_if.data !== 17'h00066)) begin
        errors++; $display("FAIL freq_item: got %b/%h want 1/00066", dout_if.valid, dout_if.data);
      end
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checks++;
        if (dout_if.valid !== 1'b1 || dout_if.data !== FILLER) begin
          errors++; $display("FAIL freq_filler[%0d][%0d]: got %b/%h", j, k, dout_if.valid, dout_if.data);
        end
      end
      @(negedge clk);
      checks++;
      if (dout_if.valid !== 1'b0) begin
        errors++; $display("FAIL freq_end[%0d]: got %b want 0", j, dout_if.valid);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_flush();
    test_eot_hold();
    test_back_to_back();
    test_stall();
    test_reset_mid_flush();
`ifdef DLY_FLUSH_REQ_EN
    test_flush_req();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
